// File: rtl/chan_regmem_if.sv
// Channel register store bus: sequencer-side address/strobes/data and operator-side read data.
// The master modport drives the request; the slave modport is the store itself.
interface chan_regmem_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4,
  parameter int LANE_W = 8
);
  localparam int NLANE = DATA_W / LANE_W;

  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic [NLANE-1:0]  wmask;
  logic [DATA_W-1:0] idata;
  logic              clr;
  logic [DATA_W-1:0] odata;
  logic              init_busy;

  modport master (
    output addr, wr, wmask, idata, clr,
    input  odata, init_busy
  );

  modport slave (
    input  addr, wr, wmask, idata, clr,
    output odata, init_busy
  );
endinterface

// File: rtl/chan_regmem.sv
// Per-channel register store: 1R/1W, registered read, lane-masked writes, hardware clear sequence.
// Macro CHAN_REGMEM_WR_BYPASS_EN selects write-first same-address reads; default is read-before-write.
module chan_regmem #(
  parameter int                DATA_W   = 24,
  parameter int                DEPTH    = 9,
  parameter int                ADDR_W   = 4,
  parameter int                LANE_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  chan_regmem_if.slave bus
);
  localparam int                NLANE    = DATA_W / LANE_W;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] odata_q, odata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic              in_range;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_next;

  assign in_range = ({1'b0, bus.addr} < DEPTH_C);
  assign rd_word  = in_range ? mem_q[bus.addr] : '0;

  // Lanes not enabled keep the stored value, so slot sub-fields update in place.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NLANE; i++) begin
      if (bus.wmask[i]) begin
        merged[i*LANE_W +: LANE_W] = bus.idata[i*LANE_W +: LANE_W];
      end
    end
  end

`ifdef CHAN_REGMEM_WR_BYPASS_EN
  assign rd_next = (bus.wr && in_range) ? merged : rd_word;
`else
  assign rd_next = rd_word;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    odata_d = odata_q;
    mem_we  = 1'b0;
    mem_wa  = ptr_q;
    mem_wd  = INIT_VAL;
    case (state_q)
      ST_CLEAR: begin
        mem_we  = 1'b1;
        odata_d = '0;
        if (bus.clr) begin
          ptr_d  = '0;
          busy_d = 1'b1;
        end else if (ptr_q == LAST_PTR) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        mem_we  = bus.wr && in_range;
        mem_wa  = bus.addr;
        mem_wd  = merged;
        odata_d = rd_next;
        // A write coinciding with clr still lands; the sequence overwrites it later.
        if (bus.clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
        busy_d  = 1'b1;
        odata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      odata_q <= odata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign bus.odata     = odata_q;
  assign bus.init_busy = busy_q;
endmodule

// File: tb/tb_chan_regmem.sv
// Scoreboard bench for chan_regmem: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_chan_regmem;
`ifdef CHAN_REGMEM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [23:0] o;
    logic        b;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [23:0] old1 [9];

  chan_regmem_if #(.DATA_W(24), .ADDR_W(4), .LANE_W(8)) bus ();

  chan_regmem #(
    .DATA_W(24), .DEPTH(9), .ADDR_W(4), .LANE_W(8), .INIT_VAL(24'h000000)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.nm, e.cyc, cyc);
      end else if (bus.odata !== e.o || bus.init_busy !== e.b) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: odata=%h busy=%b, expected odata=%h busy=%b",
                 e.nm, cyc, bus.odata, bus.init_busy, e.o, e.b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input logic [23:0] o, input logic b, input string nm);
    exp_t e;
    e.cyc = cyc; e.o = o; e.b = b; e.nm = nm;
    sb.push_back(e);
  endtask

  // Present one cycle of inputs; the expectation is for the outputs after the next edge.
  task automatic drive(input logic [3:0] a, input logic w, input logic [2:0] m,
                       input logic [23:0] d, input logic c,
                       input logic [23:0] exp_o, input logic exp_b, input string nm);
    exp_t e;
    bus.addr = a; bus.wr = w; bus.wmask = m; bus.idata = d; bus.clr = c;
    e.cyc = cyc + 1; e.o = exp_o; e.b = exp_b; e.nm = nm;
    sb.push_back(e);
    step();
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < 9; a++) drive(4'(a), 1'b0, 3'b000, 24'h0, 1'b0, 24'h0, 1'b0, nm);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    old1[0] = 24'h0; old1[1] = 24'h0; old1[2] = 24'h000022; old1[3] = 24'h0;
    old1[4] = 24'h0; old1[5] = 24'hFF34AA; old1[6] = 24'h0; old1[7] = 24'h0; old1[8] = 24'h0;
    bus.addr = '0; bus.wr = 1'b0; bus.wmask = '0; bus.idata = '0; bus.clr = 1'b0;
    step();
    step();
    expect_now(24'h0, 1'b1, "reset_state");

    // 1: release reset with a write held; busy for 9 cycles, writes dropped
    rst = 1'b0;
    for (int j = 1; j <= 9; j++)
      drive(4'd3, 1'b1, 3'b111, 24'hABCDEF, 1'b0, 24'h0, (j <= 8), "init_busy");
    read_all_zero("init_contents");

    // 2: lane-masked writes
    drive(4'd5, 1'b1, 3'b111, 24'h123456, 1'b0, BYP ? 24'h123456 : 24'h0, 1'b0, "mask_wr_full");
    drive(4'd5, 1'b1, 3'b101, 24'hFF00AA, 1'b0, BYP ? 24'hFF34AA : 24'h123456, 1'b0, "mask_wr_101");
    drive(4'd5, 1'b0, 3'b000, 24'h0, 1'b0, 24'hFF34AA, 1'b0, "mask_rd");

    // 3: same-cycle read/write
    drive(4'd2, 1'b1, 3'b111, 24'h000011, 1'b0, BYP ? 24'h000011 : 24'h0, 1'b0, "rw_first");
    drive(4'd2, 1'b1, 3'b111, 24'h000022, 1'b0, BYP ? 24'h000022 : 24'h000011, 1'b0, "rw_same");
    drive(4'd2, 1'b0, 3'b000, 24'h0, 1'b0, 24'h000022, 1'b0, "rw_after");
    drive(4'd2, 1'b1, 3'b000, 24'hFFFFFF, 1'b0, 24'h000022, 1'b0, "wmask0_wr");
    drive(4'd2, 1'b0, 3'b000, 24'h0, 1'b0, 24'h000022, 1'b0, "wmask0_rd");

    // 4: out-of-range
    drive(4'd9, 1'b1, 3'b111, 24'h777777, 1'b0, 24'h0, 1'b0, "oor_9");
    drive(4'd15, 1'b1, 3'b111, 24'h777777, 1'b0, 24'h0, 1'b0, "oor_15");
    for (int a = 0; a < 9; a++)
      drive(4'(a), 1'b0, 3'b000, 24'h0, 1'b0, old1[a], 1'b0, "oor_unchanged");

    // 5a: fill then single clr pulse
    for (int n = 0; n < 9; n++)
      drive(4'(n), 1'b1, 3'b111, 24'(n + 1), 1'b0, BYP ? 24'(n + 1) : old1[n], 1'b0, "fill1");
    drive(4'd8, 1'b0, 3'b000, 24'h0, 1'b0, 24'd9, 1'b0, "fill1_rd");
    drive(4'd0, 1'b0, 3'b000, 24'h0, 1'b1, 24'd1, 1'b1, "clr_edge");
    for (int j = 1; j <= 9; j++)
      drive(4'd0, 1'b1, 3'b111, 24'h111111, 1'b0, 24'h0, (j <= 8), "clr_busy");
    read_all_zero("clr_contents");

    // 5b: clr with coincident write, then re-pulse 4 cycles into the sequence
    for (int n = 0; n < 9; n++)
      drive(4'(n), 1'b1, 3'b111, 24'(n + 1), 1'b0, BYP ? 24'(n + 1) : 24'h0, 1'b0, "fill2");
    drive(4'd4, 1'b1, 3'b111, 24'h555555, 1'b1, BYP ? 24'h555555 : 24'd5, 1'b1, "clr_wr_edge");
    for (int j = 1; j <= 13; j++)
      drive(4'd4, 1'b0, 3'b000, 24'h0, (j == 4), 24'h0, (j <= 12), "reclr_busy");
    read_all_zero("reclr_contents");

    // 6: async reset mid-sequence at ptr=4
    for (int n = 0; n < 9; n++)
      drive(4'(n), 1'b1, 3'b111, 24'(n + 1), 1'b0, BYP ? 24'(n + 1) : 24'h0, 1'b0, "fill3");
    drive(4'd7, 1'b0, 3'b000, 24'h0, 1'b1, 24'd8, 1'b1, "clr3_edge");
    for (int j = 1; j <= 4; j++)
      drive(4'd7, 1'b0, 3'b000, 24'h0, 1'b0, 24'h0, 1'b1, "clr3_busy");
    #1;
    rst = 1'b1;
    expect_now(24'h0, 1'b1, "rst_async");
    step();
    expect_now(24'h0, 1'b1, "rst_hold");
    rst = 1'b0;
    for (int j = 1; j <= 9; j++)
      drive(4'd7, 1'b0, 3'b000, 24'h0, 1'b0, 24'h0, (j <= 8), "rst_rerun_busy");
    read_all_zero("rst_contents");

    bus.wr = 1'b0;
    step();
    step();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chan_regmem.md
Name: chan_regmem

Overview:
Parametrised per-channel register store for the FM synthesis core.
- 1 read/1 write, registered read.
- Hardware self-clear sequence after reset or on request; busy flag exposed.
- Lane-masked writes, so slot sub-fields update without read-modify-write.
- Sits between the channel sequencer (address and write strobes) and the operator pipeline (consumes odata).

Parameters:
DATA_W, 24, word width in bits; must be a multiple of LANE_W
DEPTH, 9, number of entries (channels)
ADDR_W, 4, address width; 2**ADDR_W >= DEPTH
LANE_W, 8, bits per write-mask lane; NLANE = DATA_W/LANE_W
INIT_VAL, 0, DATA_W-bit value written to every entry by the clear sequence

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
addr  in  ADDR_W  read/write address, shared
wr  in  1  write strobe, sampled on clk rising edge
wmask  in  NLANE  lane enables; bit i covers idata[i*LANE_W +: LANE_W]
idata  in  DATA_W  write data
clr  in  1  synchronous request to rerun the clear sequence
odata  out  DATA_W  registered read data
init_busy  out  1  high while the clear sequence runs

Behaviour:
- Reset (async, active-high):
  - odata=0, init_busy=1, clear pointer=0, state=CLEAR.
  - Array contents are not reset directly; the clear sequence clears them.
- State CLEAR:
  - Each cycle, write INIT_VAL to entry[ptr] (all lanes), then ptr++.
  - Leave for READY on the cycle the entry at ptr=DEPTH-1 is written.
  - init_busy drops on the following edge, DEPTH cycles after reset release.
  - wr is ignored and dropped, not queued.
  - odata is held at 0.
- State READY:
  - Write: if wr=1 and addr<DEPTH, each lane i with wmask[i]=1 takes idata's lane i; other lanes keep their value.
  - wr with wmask=0 is a no-op.
- Read, every READY cycle:
  - odata <= entry[addr]; 1-cycle latency.
  - On a same-cycle write to the same address, odata returns the OLD word (read-before-write) unless the Optional Feature is enabled.
- Out-of-range address (addr>=DEPTH): write ignored, no aliasing; odata <= 0.
- clr:
  - clr=1 in READY → next edge: state=CLEAR, ptr=0, init_busy=1.
  - A write in that same cycle is still performed, then overwritten by the sequence.
  - clr=1 during CLEAR restarts the sequence with ptr=0.
- Reset mid-CLEAR: the sequence restarts from entry 0; no partial state carries over.
- Pointer is ADDR_W bits wide; it never exceeds DEPTH-1 and never wraps.

Optional Feature:
- Macro: CHAN_REGMEM_WR_BYPASS_EN.
- Defined: a READY-state write to addr<DEPTH with the same read address gives write-first data. odata lane i = idata lane i where wmask[i]=1, else the old stored lane.
- Undefined: read-before-write as above.
- CLEAR-state and out-of-range behaviour are identical either way.

Test Plan:
1. Reset (DEPTH=9):
   - Release reset, hold wr=1 with idata=0xABCDEF at addr 3 throughout.
   - init_busy stays 1 for 9 cycles, then 0.
   - Reading addr 0..8 returns 0x000000; the writes during CLEAR are dropped.
2. Lane-masked write:
   - After init, write 0x123456 to addr 5 with wmask=111.
   - Then write 0xFF00AA with wmask=101.
   - Reading addr 5 returns 0xFF34AA, one cycle after addr is presented.
3. Same-cycle read/write:
   - addr 2 holds 0x000011; write 0x000022 to addr 2 with wmask=111 while reading addr 2.
   - Without the macro: odata=0x000011, next cycle 0x000022.
   - With CHAN_REGMEM_WR_BYPASS_EN: odata=0x000022 immediately.
4. Out of range:
   - Write 0x777777 to addr 9 and addr 15.
   - odata=0 for those addresses; entries 0..8 are unchanged (addr 1, which aliases 9 mod 8, is still 0).
5. clr:
   - With entries filled (addr n = n+1), pulse clr for one cycle.
   - init_busy rises on the next edge for 9 cycles; afterwards all entries read INIT_VAL.
   - Pulse clr again 4 cycles into CLEAR: busy lasts 9 more cycles from the second pulse.
6. Reset mid-CLEAR:
   - Assert reset asynchronously at ptr=4; odata drops to 0 immediately.
   - After release, the full 9-cycle sequence runs from entry 0.
